// File: rtl/message_scroller.sv
// Sliding 4-character window over a fixed 16-character message, advanced on a
// programmable interval (RUN) or by manual step pulses (PAUSED).
module message_scroller #(
  parameter int SCROLL_TICKS = 1562500,
  parameter int CNT_W        = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        step,
  input  logic        dir,
  output logic [15:0] message,
  output logic        msg_valid,
  output logic [3:0]  position,
  output logic        running
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(SCROLL_TICKS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pos;
  logic [15:0]      r_msg;
  logic             r_vld;
  logic             r_run;
  logic [3:0]       w_adv;

  // The message ROM is the identity table char[i] = i, so each window slot
  // is simply its own index.
  function automatic logic [15:0] f_win(input logic [3:0] p);
    return {p, p + 4'd1, p + 4'd2, p + 4'd3};
  endfunction

  assign w_adv = dir ? r_pos - 4'd1 : r_pos + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_msg   <= 16'h0123;
      r_vld   <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_msg   <= f_win(4'd0);
          end
        end
        RUN: begin
          if (start) begin
            r_cnt <= '0;
            r_pos <= '0;
            r_msg <= f_win(4'd0);
            r_vld <= 1'b1;
          end else if (pause) begin
            // Counter holds, so a tick lost to pause fires on the first RUN cycle after resume.
            r_state <= PAUSED;
            r_run   <= 1'b0;
          end else if (r_cnt == TERM) begin
            r_cnt <= '0;
            r_pos <= w_adv;
            r_msg <= f_win(w_adv);
            r_vld <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PAUSED: begin
          if (start) begin
            r_state <= RUN;
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_msg   <= f_win(4'd0);
            r_vld   <= 1'b1;
          end else if (pause) begin
            r_state <= RUN;
            r_run   <= 1'b1;
          end else if (step) begin
            r_pos <= w_adv;
            r_msg <= f_win(w_adv);
            r_vld <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  assign message   = r_msg;
  assign msg_valid = r_vld;
  assign position  = r_pos;
  assign running   = r_run;

endmodule
